// File: rtl/motor_control_mc.sv
// Multi-channel motor command stage: run/stop/fault FSM, clamped steering offset,
// rpm setpoint slewing and saturating duty accumulation. MOTOR_CONTROL_RPM_RAMP_EN enables slewing.
module motor_control_mc #(
  parameter int unsigned       NUM_CH         = 2,
  parameter int unsigned       PWM_RESOLUTION = 16,
  parameter int unsigned       RPM_RESOLUTION = 16,
  parameter int unsigned       MAX_RPM_OFFSET = 50,
  parameter int unsigned       DUTY_LIMIT_PCT = 75,
  parameter int unsigned       RAMP_STEP      = 4,
  parameter logic [NUM_CH-1:0] CH_SIGN        = NUM_CH'(2'b10)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clk_en,
  input  logic                                enable,
  input  logic                                estop,
  input  logic [NUM_CH*(PWM_RESOLUTION+1)-1:0] duty_cycle_offset,
  input  logic [RPM_RESOLUTION-1:0]           base_rpm,
  input  logic [RPM_RESOLUTION:0]             rpm_offset,
  output logic [NUM_CH*PWM_RESOLUTION-1:0]    duty_cycle,
  output logic [NUM_CH*RPM_RESOLUTION-1:0]    rpm_setpoint,
  output logic [NUM_CH-1:0]                   sat_flags,
  output logic                                ramp_done,
  output logic [1:0]                          state
);

  localparam int unsigned PW = PWM_RESOLUTION;
  localparam int unsigned RW = RPM_RESOLUTION;
  localparam int unsigned OW = PWM_RESOLUTION + 1;
  localparam int unsigned SW = PWM_RESOLUTION + 2;
  localparam int unsigned TW = RPM_RESOLUTION + 2;
  localparam int unsigned DUTY_LIMIT = (((1 << PW) - 1) * DUTY_LIMIT_PCT) / 100;

  localparam logic signed [SW-1:0] DUTY_LIM_S = SW'(DUTY_LIMIT);
  localparam logic signed [TW-1:0] OFF_MAX    = TW'(MAX_RPM_OFFSET);
  localparam logic signed [TW-1:0] OFF_MIN    = -OFF_MAX;
  localparam logic signed [TW-1:0] RPM_MAX    = TW'((1 << RW) - 1);
`ifdef MOTOR_CONTROL_RPM_RAMP_EN
  localparam logic signed [TW-1:0] STEP_S     = TW'(RAMP_STEP);
`else
  // Wider than any reachable |target - setpoint|, so setpoints land on target every update
  localparam logic signed [TW-1:0] STEP_S     = {1'b0, {(TW-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STOP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic signed [TW-1:0]     off_ext, off_c;
  logic signed [TW-1:0]     ch_tsum, ch_diff;
  logic signed [SW-1:0]     ch_dsum;
  logic [OW-1:0]            ch_doff;
  logic [RW-1:0]            ch_tgt, ch_sp, ch_sp_nxt;
  logic [PW-1:0]            ch_duty_nxt;
  logic                     ch_sat_nxt;
  logic [NUM_CH*RW-1:0]     sp_d;
  logic [NUM_CH*PW-1:0]     duty_d;
  logic [NUM_CH-1:0]        sat_d;
  logic                     sp_match, sp_zero;
  logic                     duty_live;

  // Steering offset clamped to +/-MAX_RPM_OFFSET
  always_comb begin
    off_ext = $signed({rpm_offset[RW], rpm_offset});
    if (off_ext > OFF_MAX)      off_c = OFF_MAX;
    else if (off_ext < OFF_MIN) off_c = OFF_MIN;
    else                        off_c = off_ext;
  end

  // Per-channel target, setpoint slew and duty accumulation
  always_comb begin
    ch_tsum     = '0;
    ch_diff     = '0;
    ch_dsum     = '0;
    ch_doff     = '0;
    ch_tgt      = '0;
    ch_sp       = '0;
    ch_sp_nxt   = '0;
    ch_duty_nxt = '0;
    ch_sat_nxt  = 1'b0;
    sp_d        = rpm_setpoint;
    duty_d      = duty_cycle;
    sat_d       = '0;
    sp_match    = 1'b1;
    sp_zero     = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_SIGN[i]) ch_tsum = $signed({2'b00, base_rpm}) - off_c;
      else            ch_tsum = $signed({2'b00, base_rpm}) + off_c;

      if (state_q != ST_RUN)     ch_tgt = '0;
      else if (ch_tsum[TW-1])    ch_tgt = '0;
      else if (ch_tsum > RPM_MAX) ch_tgt = '1;
      else                       ch_tgt = RW'(ch_tsum);

      ch_sp   = rpm_setpoint[i*RW +: RW];
      ch_diff = $signed({2'b00, ch_tgt}) - $signed({2'b00, ch_sp});
      if (ch_diff > STEP_S)       ch_sp_nxt = ch_sp + RW'(RAMP_STEP);
      else if (ch_diff < -STEP_S) ch_sp_nxt = ch_sp - RW'(RAMP_STEP);
      else                        ch_sp_nxt = ch_tgt;
      sp_d[i*RW +: RW] = ch_sp_nxt;
      if (ch_sp_nxt != ch_tgt) sp_match = 1'b0;
      if (ch_sp_nxt != '0)     sp_zero  = 1'b0;

      // A sum landing exactly on the ceiling is passed through, not flagged
      ch_doff = duty_cycle_offset[i*OW +: OW];
      ch_dsum = $signed({2'b00, duty_cycle[i*PW +: PW]}) + $signed({ch_doff[OW-1], ch_doff});
      if (ch_dsum[SW-1]) begin
        ch_duty_nxt = '0;
        ch_sat_nxt  = 1'b1;
      end else if (ch_dsum >= DUTY_LIM_S) begin
        ch_duty_nxt = PW'(DUTY_LIMIT);
        ch_sat_nxt  = (ch_dsum != DUTY_LIM_S);
      end else begin
        ch_duty_nxt = PW'(ch_dsum);
        ch_sat_nxt  = 1'b0;
      end
      duty_d[i*PW +: PW] = ch_duty_nxt;
      sat_d[i]           = ch_sat_nxt;
    end
  end

  // Next-state logic; estop overrides the update strobe
  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = ST_FAULT;
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE:  if (enable) state_d = ST_RUN;
        ST_RUN:   if (!enable) state_d = ST_STOP;
        ST_STOP: begin
          if (enable)       state_d = ST_RUN;
          else if (sp_zero) state_d = ST_IDLE;
        end
        ST_FAULT: if (!enable) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign duty_live = ((state_q == ST_RUN) || (state_q == ST_STOP)) && (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n || estop) begin
      duty_cycle   <= '0;
      rpm_setpoint <= '0;
      sat_flags    <= '0;
      ramp_done    <= 1'b0;
    end else if (clk_en) begin
      rpm_setpoint <= sp_d;
      ramp_done    <= sp_match;
      if (duty_live) begin
        duty_cycle <= duty_d;
        sat_flags  <= sat_d;
      end else begin
        duty_cycle <= '0;
        sat_flags  <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_motor_control_mc.sv
// Self-checking bench for motor_control_mc: behavioural model feeds a scoreboard queue,
// plus directed checks per feature.
module tb_motor_control_mc;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        enable;
  logic        estop;
  logic [33:0] duty_cycle_offset;
  logic [15:0] base_rpm;
  logic [16:0] rpm_offset;
  logic [31:0] duty_cycle;
  logic [31:0] rpm_setpoint;
  logic [1:0]  sat_flags;
  logic        ramp_done;
  logic [1:0]  state;

  motor_control_mc dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clk_en            (clk_en),
    .enable            (enable),
    .estop             (estop),
    .duty_cycle_offset (duty_cycle_offset),
    .base_rpm          (base_rpm),
    .rpm_offset        (rpm_offset),
    .duty_cycle        (duty_cycle),
    .rpm_setpoint      (rpm_setpoint),
    .sat_flags         (sat_flags),
    .ramp_done         (ramp_done),
    .state             (state)
  );

  localparam int DL = 49151;
`ifdef MOTOR_CONTROL_RPM_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] duty;
    logic [31:0] sp;
    logic [1:0]  sat;
    logic        rd;
    logic [1:0]  st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  int   base;
  int   roff;
  int   dofs [2];
  int   m_sp [2];
  int   m_duty [2];
  bit   m_sat [2];
  bit   m_rd;
  int   m_st;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int ramp_exp(input int k, input int tgt);
    return (RAMP && (4 * k < tgt)) ? 4 * k : tgt;
  endfunction

  task automatic model_step();
    int off, s, ns;
    int tgt [2];
    int nsp [2];
    bit allz;
    if (!reset_n || estop) begin
      for (int i = 0; i < 2; i++) begin
        m_sp[i] = 0; m_duty[i] = 0; m_sat[i] = 1'b0;
      end
      m_rd = 1'b0;
      m_st = reset_n ? 3 : 0;
    end else if (clk_en) begin
      off  = clampi(roff, -50, 50);
      m_rd = 1'b1;
      allz = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tgt[i] = (m_st == 1) ? clampi((i == 1) ? base - off : base + off, 0, 65535) : 0;
        if (!RAMP || (tgt[i] - m_sp[i] <= 4 && m_sp[i] - tgt[i] <= 4)) nsp[i] = tgt[i];
        else if (tgt[i] > m_sp[i]) nsp[i] = m_sp[i] + 4;
        else nsp[i] = m_sp[i] - 4;
        if (nsp[i] != tgt[i]) m_rd = 1'b0;
        if (nsp[i] != 0) allz = 1'b0;
      end
      ns = m_st;
      case (m_st)
        0: if (enable) ns = 1;
        1: if (!enable) ns = 2;
        2: if (enable) ns = 1; else if (allz) ns = 0;
        default: if (!enable) ns = 0;
      endcase
      for (int i = 0; i < 2; i++) begin
        if ((m_st == 1 || m_st == 2) && ns != 0) begin
          s = m_duty[i] + dofs[i];
          if (s > DL)       begin m_duty[i] = DL; m_sat[i] = 1'b1; end
          else if (s == DL) begin m_duty[i] = DL; m_sat[i] = 1'b0; end
          else if (s < 0)   begin m_duty[i] = 0;  m_sat[i] = 1'b1; end
          else              begin m_duty[i] = s;  m_sat[i] = 1'b0; end
        end else begin
          m_duty[i] = 0; m_sat[i] = 1'b0;
        end
        m_sp[i] = nsp[i];
      end
      m_st = ns;
    end
  endtask

  // One clock: apply inputs, queue the model's post-edge expectation, return after the edge
  task automatic cycle(input bit ce);
    exp_t e;
    @(negedge clk);
    clk_en            = ce;
    duty_cycle_offset = {17'(dofs[1]), 17'(dofs[0])};
    base_rpm          = 16'(base);
    rpm_offset        = 17'(roff);
    model_step();
    e.duty = {16'(m_duty[1]), 16'(m_duty[0])};
    e.sp   = {16'(m_sp[1]), 16'(m_sp[0])};
    e.sat  = {m_sat[1], m_sat[0]};
    e.rd   = m_rd;
    e.st   = 2'(m_st);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic update();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (duty_cycle !== mon_e.duty) begin
        n_errors++; $display("FAIL sb_duty: got %h expected %h at %0t", duty_cycle, mon_e.duty, $time);
      end
      n_checks++;
      if (rpm_setpoint !== mon_e.sp) begin
        n_errors++; $display("FAIL sb_setpoint: got %h expected %h at %0t", rpm_setpoint, mon_e.sp, $time);
      end
      n_checks++;
      if (sat_flags !== mon_e.sat) begin
        n_errors++; $display("FAIL sb_sat: got %b expected %b at %0t", sat_flags, mon_e.sat, $time);
      end
      n_checks++;
      if (ramp_done !== mon_e.rd) begin
        n_errors++; $display("FAIL sb_ramp_done: got %b expected %b at %0t", ramp_done, mon_e.rd, $time);
      end
      n_checks++;
      if (state !== mon_e.st) begin
        n_errors++; $display("FAIL sb_state: got %b expected %b at %0t", state, mon_e.st, $time);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enable  = 1'($urandom_range(0, 1));
      estop   = 1'($urandom_range(0, 1));
      base    = int'($urandom_range(0, 65535));
      roff    = int'($urandom_range(0, 400)) - 200;
      dofs[0] = int'($urandom_range(0, 131071)) - 65536;
      dofs[1] = int'($urandom_range(0, 131071)) - 65536;
      cycle(1'($urandom_range(0, 1)));
    end
    n_checks++;
    if ({duty_cycle, rpm_setpoint, sat_flags, ramp_done} !== 67'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", {duty_cycle, rpm_setpoint, sat_flags, ramp_done});
    end
    n_checks++;
    if (state !== 2'b00) begin
      n_errors++; $display("FAIL reset_state: got %b expected 00", state);
    end
    reset_n = 1'b1; estop = 1'b0; enable = 1'b0;
    base = 0; roff = 0; dofs[0] = 0; dofs[1] = 0;
    update();
  endtask

  task automatic test_ramp_up();
    enable = 1'b1; base = 100; roff = 20;
    update();
    n_checks++;
    if (state !== 2'b01) begin
      n_errors++; $display("FAIL ramp_enter_run: got %b expected 01", state);
    end
    for (int k = 1; k <= 30; k++) begin
      update();
      if (k == 1 || k == 20 || k == 29 || k == 30) begin
        n_checks++;
        if (rpm_setpoint !== {16'(ramp_exp(k, 80)), 16'(ramp_exp(k, 120))}) begin
          n_errors++; $display("FAIL ramp_sp_u%0d: got %h expected %h", k, rpm_setpoint,
                               {16'(ramp_exp(k, 80)), 16'(ramp_exp(k, 120))});
        end
        n_checks++;
        if (ramp_done !== (ramp_exp(k, 120) == 120)) begin
          n_errors++; $display("FAIL ramp_done_u%0d: got %b expected %b", k, ramp_done, ramp_exp(k, 120) == 120);
        end
      end
    end
  endtask

  task automatic test_duty_sat();
    dofs[0] = 49000; dofs[1] = 1000;
    update();
    n_checks++;
    if (duty_cycle[15:0] !== 16'd49000 || sat_flags[0] !== 1'b0) begin
      n_errors++; $display("FAIL duty_load: got %0d/%b expected 49000/0", duty_cycle[15:0], sat_flags[0]);
    end
    dofs[0] = 500; dofs[1] = -5000;
    update();
    n_checks++;
    if (duty_cycle[15:0] !== 16'd49151 || sat_flags[0] !== 1'b1) begin
      n_errors++; $display("FAIL duty_ceiling: got %0d/%b expected 49151/1", duty_cycle[15:0], sat_flags[0]);
    end
    n_checks++;
    if (duty_cycle[31:16] !== 16'd0 || sat_flags[1] !== 1'b1) begin
      n_errors++; $display("FAIL duty_floor_ch1: got %0d/%b expected 0/1", duty_cycle[31:16], sat_flags[1]);
    end
    dofs[0] = 0; dofs[1] = 0;
    update();
    n_checks++;
    if (duty_cycle[15:0] !== 16'd49151 || sat_flags[0] !== 1'b0) begin
      n_errors++; $display("FAIL duty_hold_clear: got %0d/%b expected 49151/0", duty_cycle[15:0], sat_flags[0]);
    end
    dofs[0] = -60000;
    update();
    n_checks++;
    if (duty_cycle[15:0] !== 16'd0 || sat_flags[0] !== 1'b1) begin
      n_errors++; $display("FAIL duty_floor: got %0d/%b expected 0/1", duty_cycle[15:0], sat_flags[0]);
    end
    dofs[0] = 0;
  endtask

  task automatic test_offset_clamp();
    roff = 200;
    repeat (10) cycle(1'b1);
    n_checks++;
    if (rpm_setpoint !== {16'd50, 16'd150}) begin
      n_errors++; $display("FAIL clamp_pos: got %h expected %h", rpm_setpoint, {16'd50, 16'd150});
    end
    roff = -200;
    repeat (26) cycle(1'b1);
    n_checks++;
    if (rpm_setpoint !== {16'd150, 16'd50}) begin
      n_errors++; $display("FAIL clamp_neg: got %h expected %h", rpm_setpoint, {16'd150, 16'd50});
    end
    base = 20; roff = 200;
    repeat (40) cycle(1'b1);
    n_checks++;
    if (rpm_setpoint !== {16'd0, 16'd70}) begin
      n_errors++; $display("FAIL clamp_floor: got %h expected %h", rpm_setpoint, {16'd0, 16'd70});
    end
    base = 65530; roff = 50;
    repeat (16400) cycle(1'b1);
    n_checks++;
    if (rpm_setpoint !== {16'd65480, 16'd65535}) begin
      n_errors++; $display("FAIL clamp_ceiling: got %h expected %h", rpm_setpoint, {16'd65480, 16'd65535});
    end
  endtask

  task automatic test_estop();
    base = 100; roff = 20; dofs[0] = 1234;
    repeat (5) cycle(1'b1);
    estop = 1'b1;
    cycle(1'b0);
    n_checks++;
    if ({duty_cycle, rpm_setpoint, sat_flags, ramp_done} !== 67'd0) begin
      n_errors++; $display("FAIL estop_outputs: got %h expected 0", {duty_cycle, rpm_setpoint, sat_flags, ramp_done});
    end
    n_checks++;
    if (state !== 2'b11) begin
      n_errors++; $display("FAIL estop_state: got %b expected 11", state);
    end
    estop = 1'b0; enable = 1'b1;
    update();
    update();
    n_checks++;
    if (state !== 2'b11 || duty_cycle !== 32'd0) begin
      n_errors++; $display("FAIL fault_hold: got %b/%h expected 11/0", state, duty_cycle);
    end
    enable = 1'b0;
    update();
    n_checks++;
    if (state !== 2'b00) begin
      n_errors++; $display("FAIL fault_exit: got %b expected 00", state);
    end
    dofs[0] = 0;
  endtask

  task automatic test_stop();
    int cnt;
    bit done;
    enable = 1'b1; base = 100; roff = 20; dofs[0] = 300; dofs[1] = 700;
    repeat (31) update();
    n_checks++;
    if (rpm_setpoint !== {16'd80, 16'd120} || state !== 2'b01) begin
      n_errors++; $display("FAIL stop_start: got %h/%b expected %h/01", rpm_setpoint, state, {16'd80, 16'd120});
    end
    enable = 1'b0;
    update();
    n_checks++;
    if (state !== 2'b10 || rpm_setpoint !== {16'd80, 16'd120}) begin
      n_errors++; $display("FAIL stop_enter: got %b/%h expected 10/%h", state, rpm_setpoint, {16'd80, 16'd120});
    end
    repeat (10) update();
    n_checks++;
    if (rpm_setpoint !== {16'(RAMP ? 40 : 0), 16'(RAMP ? 80 : 0)} || state !== 2'(RAMP ? 2 : 0)) begin
      n_errors++; $display("FAIL stop_ramp_down: got %h/%b expected %h/%0d", rpm_setpoint, state,
                           {16'(RAMP ? 40 : 0), 16'(RAMP ? 80 : 0)}, RAMP ? 2 : 0);
    end
    enable = 1'b1;
    update();
    n_checks++;
    if (state !== 2'b01 || rpm_setpoint !== {16'(RAMP ? 36 : 0), 16'(RAMP ? 76 : 0)}) begin
      n_errors++; $display("FAIL stop_resume: got %b/%h expected 01/%h", state, rpm_setpoint,
                           {16'(RAMP ? 36 : 0), 16'(RAMP ? 76 : 0)});
    end
    repeat (15) update();
    enable = 1'b0;
    update();
    cnt = 0; done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      update();
      if (state == 2'b00) begin
        cnt = k; done = 1'b1;
      end
    end
    n_checks++;
    if (cnt != (RAMP ? 30 : 1)) begin
      n_errors++; $display("FAIL stop_to_idle: got %0d updates expected %0d (0 = no idle within 100)", cnt, RAMP ? 30 : 1);
    end
    n_checks++;
    if (duty_cycle !== 32'd0 || sat_flags !== 2'b00) begin
      n_errors++; $display("FAIL idle_duty_clear: got %h/%b expected 0/00", duty_cycle, sat_flags);
    end
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; enable = 1'b0; estop = 1'b0;
    base = 0; roff = 0; dofs[0] = 0; dofs[1] = 0;
    duty_cycle_offset = '0; base_rpm = '0; rpm_offset = '0;
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 0; m_duty[i] = 0; m_sat[i] = 1'b0;
    end
    m_rd = 1'b0; m_st = 0;
    test_reset();
    test_ramp_up();
    test_duty_sat();
    test_offset_clamp();
    test_estop();
    test_stop();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
